// File: rtl/spu_ls_pkg.sv
// Shared LocalStore types and constants for the SPU LocalStore port arbiter.
package spu_ls_pkg;

  localparam int LS_ADDR_W = 15;
  localparam int QW_W      = 128;
  localparam int QW_BYTES  = 16;

  typedef enum logic [1:0] {REQ_LSU, REQ_IF, REQ_DMA} ls_req_e;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_COOLDOWN} ls_arb_state_e;

  // Clear the byte-within-quadword bits, so an access never crosses a quadword
  function automatic logic [LS_ADDR_W-1:0] align_qw(input logic [LS_ADDR_W-1:0] addr);
    return addr & ~LS_ADDR_W'(QW_BYTES - 1);
  endfunction

endpackage

// File: rtl/ls_starve_ctr.sv
// Per-requester wait counter; raises promote once a requester has waited STARVE_LIMIT cycles.
module ls_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic promote
);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (!req || gnt) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign promote = req && (wait_cnt >= 8'(STARVE_LIMIT));

endmodule

// File: rtl/ls_port_arbiter.sv
// LocalStore port arbiter: LSU > IF > DMA with starvation promotion and a DMA burst lock.
//   state    | meaning
//   IDLE     | normal arbitration, promoted requesters first
//   BURST    | DMA owns the port while dma_req & dma_lock hold
//   COOLDOWN | one cycle with DMA excluded after a burst
module ls_port_arbiter
  import spu_ls_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lsu_req,
  input  logic                 lsu_we,
  input  logic [0:LS_ADDR_W-1] lsu_addr,
  input  logic [0:QW_W-1]      lsu_wdata,
  output logic                 lsu_gnt,
  output logic                 lsu_rvalid,
  input  logic                 if_req,
  input  logic [0:LS_ADDR_W-1] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic                 dma_lock,
  input  logic [0:LS_ADDR_W-1] dma_addr,
  input  logic [0:QW_W-1]      dma_wdata,
  output logic                 dma_gnt,
  output logic                 dma_rvalid,
  output logic [0:QW_W-1]      rdata,
  output logic                 LS_write_en,
  output logic [0:LS_ADDR_W-1] LS_addr,
  output logic [0:QW_W-1]      LS_data_in,
  input  logic [0:QW_W-1]      LS_data_out,
  output logic [0:15]          conflict_cnt
);

  ls_arb_state_e state_q, state_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  ls_req_e       sel;
  logic          gnt_any, gnt_v, dma_allowed;
  logic          if_promote, dma_promote;

  ls_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_if_starve (
    .clk(clk), .rst_n(rst_n), .req(if_req), .gnt(if_gnt), .promote(if_promote)
  );

  ls_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_dma_starve (
    .clk(clk), .rst_n(rst_n), .req(dma_req), .gnt(dma_gnt), .promote(dma_promote)
  );

  // DMA may only win in IDLE, or in BURST while its lock is still held
  always_comb begin
    sel         = REQ_LSU;
    gnt_any     = 1'b0;
    dma_allowed = (state_q == ST_IDLE);
    if (state_q == ST_BURST && dma_req && dma_lock) begin
      sel = REQ_DMA; gnt_any = 1'b1;
    end else if (dma_allowed && dma_promote) begin
      sel = REQ_DMA; gnt_any = 1'b1;
    end else if (if_promote) begin
      sel = REQ_IF;  gnt_any = 1'b1;
    end else if (lsu_req) begin
      sel = REQ_LSU; gnt_any = 1'b1;
    end else if (if_req) begin
      sel = REQ_IF;  gnt_any = 1'b1;
    end else if (dma_allowed && dma_req) begin
      sel = REQ_DMA; gnt_any = 1'b1;
    end
  end

  assign gnt_v   = gnt_any & rst_n;
  assign lsu_gnt = gnt_v && (sel == REQ_LSU);
  assign if_gnt  = gnt_v && (sel == REQ_IF);
  assign dma_gnt = gnt_v && (sel == REQ_DMA);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dma_gnt && dma_lock) begin
          burst_cnt_d = 4'd1;
          state_d     = (MAX_BURST <= 1) ? ST_COOLDOWN : ST_BURST;
        end
      end
      ST_BURST: begin
        if (dma_gnt) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
          if (32'(burst_cnt_q) + 32'd1 >= MAX_BURST) state_d = ST_COOLDOWN;
        end else begin
          state_d = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        state_d     = ST_IDLE;
        burst_cnt_d = 4'd0;
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    LS_addr     = '0;
    LS_data_in  = '0;
    LS_write_en = 1'b0;
    if (gnt_v) begin
      case (sel)
        REQ_LSU: begin
          LS_addr     = align_qw(lsu_addr);
          LS_data_in  = lsu_wdata;
          LS_write_en = lsu_we;
        end
        REQ_IF: LS_addr = align_qw(if_addr);
        REQ_DMA: begin
          LS_addr     = align_qw(dma_addr);
          LS_data_in  = dma_wdata;
          LS_write_en = dma_we;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata      <= '0;
      lsu_rvalid <= 1'b0;
      if_rvalid  <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      lsu_rvalid <= lsu_gnt && !lsu_we;
      if_rvalid  <= if_gnt;
      dma_rvalid <= dma_gnt && !dma_we;
      if (gnt_v && !LS_write_en) rdata <= LS_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= 16'd0;
    end else if (((lsu_req & if_req) | (lsu_req & dma_req) | (if_req & dma_req))
                 && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule
